// File: rtl/bsg_rr_priority_arb_ctrl.sv
// Round-robin arbiter around a lo-to-hi priority encoder. It shares one
// downstream resource among width_p requesters and registers a one-hot grant
// plus a binary tag. Grants are offered on a valid/yumi handshake. An optional
// lock keeps the search pointer on the current grantee.
module bsg_rr_priority_arb_ctrl #(
    parameter int width_p    = 32,
    parameter int lg_width_p = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [width_p-1:0]    reqs_i,
    input  logic                  lock_i,
    input  logic                  yumi_i,
    output logic [width_p-1:0]    grants_o,
    output logic [lg_width_p-1:0] tag_o,
    output logic                  v_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                  state_r, state_n;
    logic [lg_width_p-1:0]   ptr_r, ptr_n, ptr_adv;
    logic [lg_width_p-1:0]   tag_r, tag_n;
    logic [width_p-1:0]      grants_r, grants_n;
    logic [width_p-1:0]      cand;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [lg_width_p-1:0] lo_to_hi_enc(input logic [width_p-1:0] v);
        logic [lg_width_p-1:0] idx;
        idx = '0;
        for (int unsigned i = width_p; i > 0; i--) begin
            if (v[i-1]) idx = lg_width_p'(i - 1);
        end
        return idx;
    endfunction

    // First set bit at or above p, wrapping to the bottom of the vector.
    function automatic logic [lg_width_p-1:0] rr_select(input logic [width_p-1:0]    v,
                                                        input logic [lg_width_p-1:0] p);
        logic [width_p-1:0] masked;
        for (int unsigned i = 0; i < width_p; i++) begin
            masked[i] = v[i] && (i >= 32'(p));
        end
        return (|masked) ? lo_to_hi_enc(masked) : lo_to_hi_enc(v);
    endfunction

    function automatic logic [width_p-1:0] onehot(input logic [lg_width_p-1:0] idx);
        logic [width_p-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Pointer wraps at width_p rather than at 2**lg_width_p.
    assign ptr_adv = (tag_r == lg_width_p'(width_p - 1)) ? '0 : tag_r + 1'b1;

    // Without lock the finishing grantee is removed so it cannot win back-to-back.
    assign cand = lock_i ? reqs_i : (reqs_i & ~grants_r);

    // State register: FSM state, search pointer and the registered grant.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            tag_r    <= '0;
            grants_r <= '0;
        end else begin
            state_r  <= state_n;
            ptr_r    <= ptr_n;
            tag_r    <= tag_n;
            grants_r <= grants_n;
        end
    end

    // Next-state logic: pick a winner from IDLE, or advance on an accepted grant.
    always_comb begin
        state_n  = state_r;
        ptr_n    = ptr_r;
        tag_n    = tag_r;
        grants_n = grants_r;
        unique case (state_r)
            IDLE: begin
                if (|reqs_i) begin
                    state_n  = GRANT;
                    tag_n    = rr_select(reqs_i, ptr_r);
                    grants_n = onehot(tag_n);
                end
            end
            GRANT: begin
                if (yumi_i) begin
                    ptr_n = lock_i ? tag_r : ptr_adv;
                    if (|cand) begin
                        tag_n    = rr_select(cand, ptr_n);
                        grants_n = onehot(tag_n);
                    end else begin
                        state_n  = IDLE;
                        tag_n    = '0;
                        grants_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output logic: valid follows the state; grant and tag come from registers.
    always_comb begin
        v_o      = (state_r == GRANT);
        grants_o = grants_r;
        tag_o    = tag_r;
    end

    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

    grant_consistent: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(grants_o) &&
        (v_o ? (grants_o == onehot(tag_o)) : ((grants_o == '0) && (tag_o == '0))));

endmodule

// File: tb/tb_bsg_rr_priority_arb_ctrl.sv
// Directed bench for bsg_rr_priority_arb_ctrl: a 32-requester instance and a
// 5-requester instance for non-power-of-two wrap.
module tb_bsg_rr_priority_arb_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] reqs;
    logic        lock, yumi;
    logic [31:0] grants;
    logic [4:0]  tag;
    logic        v;

    logic        rst5_n;
    logic [4:0]  reqs5;
    logic        lock5, yumi5;
    logic [4:0]  grants5;
    logic [2:0]  tag5;
    logic        v5;

    int checks = 0;
    int errors = 0;

    localparam int ROT_TAGS [4] = '{4, 31, 0, 4};

    bsg_rr_priority_arb_ctrl #(.width_p(32)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .reqs_i(reqs), .lock_i(lock), .yumi_i(yumi),
        .grants_o(grants), .tag_o(tag), .v_o(v)
    );

    bsg_rr_priority_arb_ctrl #(.width_p(5)) dut5 (
        .clk_i(clk), .reset_n_i(rst5_n), .reqs_i(reqs5), .lock_i(lock5), .yumi_i(yumi5),
        .grants_o(grants5), .tag_o(tag5), .v_o(v5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reqs = '0; lock = 1'b0; yumi = 1'b0;
        rst5_n = 1'b0; reqs5 = '0; lock5 = 1'b0; yumi5 = 1'b0;
        #23;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_v got %0d want 0", v); end
        checks++; if (grants !== 32'h0) begin errors++; $display("FAIL reset_grants got %h want 0", grants); end
        checks++; if (tag !== 5'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", tag); end
        checks++; if (v5 !== 1'b0) begin errors++; $display("FAIL reset_v5 got %0d want 0", v5); end
        @(negedge clk);
        rst_n = 1'b1; rst5_n = 1'b1;
        tick();
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL idle_noreq_v got %0d want 0", v); end
    endtask

    task automatic test_first_grant();
        reqs = 32'h1;
        tick();
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL first_v got %0d want 1", v); end
        checks++; if (grants !== 32'h1) begin errors++; $display("FAIL first_grants got %h want 1", grants); end
        checks++; if (tag !== 5'd0) begin errors++; $display("FAIL first_tag got %0d want 0", tag); end
        yumi = 1'b1; reqs = '0;
        tick();
        yumi = 1'b0;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL drain_v got %0d want 0", v); end
        checks++; if (grants !== 32'h0) begin errors++; $display("FAIL drain_grants got %h want 0", grants); end
        checks++; if (tag !== 5'd0) begin errors++; $display("FAIL drain_tag got %0d want 0", tag); end
        // pointer is now 1, so requester 1 must beat requester 0
        reqs = 32'h3;
        tick();
        checks++; if (tag !== 5'd1) begin errors++; $display("FAIL ptr1_tag got %0d want 1", tag); end
        checks++; if (grants !== 32'h2) begin errors++; $display("FAIL ptr1_grants got %h want 2", grants); end
        yumi = 1'b1; reqs = '0;
        tick();
        yumi = 1'b0;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL ptr1_drain_v got %0d want 0", v); end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        reqs = 32'h8000_0011;
        tick();
        checks++; if (tag !== 5'd0) begin errors++; $display("FAIL rot_first_tag got %0d want 0", tag); end
        yumi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (v !== 1'b1 || tag !== 5'(ROT_TAGS[i]) || grants !== (32'h1 << ROT_TAGS[i])) begin
                errors++;
                $display("FAIL rot_step%0d got v=%0d tag=%0d grants=%h want v=1 tag=%0d", i, v, tag, grants, ROT_TAGS[i]);
            end
        end
        yumi = 1'b0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            reqs = (i % 2 == 1) ? 32'h0 : (32'hFFFF_0000 ^ 32'(i));
            tick();
            checks++;
            if (v !== 1'b1 || tag !== 5'd4 || grants !== 32'h10) begin
                errors++;
                $display("FAIL hold_cyc%0d got v=%0d tag=%0d grants=%h want v=1 tag=4 grants=10", i, v, tag, grants);
            end
        end
        reqs = 32'h11;
    endtask

    task automatic test_lock();
        lock = 1'b1; yumi = 1'b1;
        tick();
        checks++; if (tag !== 5'd4 || grants !== 32'h10) begin errors++; $display("FAIL lock_tag got %0d/%h want 4/10", tag, grants); end
        lock = 1'b0;
        tick();
        checks++; if (tag !== 5'd0 || grants !== 32'h1) begin errors++; $display("FAIL unlock_tag got %0d/%h want 0/1", tag, grants); end
        reqs = '0;
        tick();
        yumi = 1'b0;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL lock_drain_v got %0d want 0", v); end
    endtask

    task automatic test_width5();
        reqs5 = 5'b10001;
        tick();
        checks++; if (v5 !== 1'b1 || tag5 !== 3'd0) begin errors++; $display("FAIL w5_first got v=%0d tag=%0d want 1/0", v5, tag5); end
        yumi5 = 1'b1;
        tick();
        checks++; if (tag5 !== 3'd4 || grants5 !== 5'b10000) begin errors++; $display("FAIL w5_tag4 got %0d/%b want 4/10000", tag5, grants5); end
        tick();
        checks++; if (tag5 !== 3'd0 || grants5 !== 5'b00001) begin errors++; $display("FAIL w5_wrap got %0d/%b want 0/00001", tag5, grants5); end
        tick();
        checks++; if (tag5 !== 3'd4 || grants5 !== 5'b10000) begin errors++; $display("FAIL w5_tag4b got %0d/%b want 4/10000", tag5, grants5); end
        yumi5 = 1'b0;
    endtask

    task automatic test_async_reset();
        reqs = 32'h4;
        tick();
        checks++; if (v !== 1'b1 || tag !== 5'd2) begin errors++; $display("FAIL ar_pre got v=%0d tag=%0d want 1/2", v, tag); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (v !== 1'b0 || grants !== 32'h0 || tag !== 5'd0) begin errors++; $display("FAIL ar_zero got v=%0d tag=%0d grants=%h want 0/0/0", v, tag, grants); end
        reqs = 32'h2;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL ar_release_v got %0d want 0", v); end
        tick();
        checks++; if (v !== 1'b1 || tag !== 5'd1 || grants !== 32'h2) begin errors++; $display("FAIL ar_regrant got v=%0d tag=%0d grants=%h want 1/1/2", v, tag, grants); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_grant();
        test_back_to_back();
        test_hold();
        test_lock();
        test_width5();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
